ldm_stm_sequencer: RTL and testbench

Sequences load/store-multiple (LDM/STM) instructions through the load/store address generation stage. Accepts one multi-register request (base address, 16-bit register list, P/U/W/L bits, instruction tag). Emits one address beat per listed register, in ascending register order, under a valid/ready handshake toward the memory access stage. Finishes with a one-cycle done pulse carrying the base write-back value.

---
 rtl/ldm_stm_pkg.sv | 20 ++
 rtl/lowest_set_bit_encoder.sv | 23 ++
 rtl/ldm_stm_sequencer.sv | 159 +++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_pkg.sv
// Shared types for the LDM/STM address sequencer: FSM states, addressing modes, word size.
package ldm_stm_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Encoded as {P, U}
    typedef enum logic [1:0] {
        AM_DA = 2'b00,
        AM_IA = 2'b01,
        AM_DB = 2'b10,
        AM_IB = 2'b11
    } amode_t;

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// Priority encoder: index and one-hot of the lowest set bit, plus a flag for "exactly one bit set".
// Purely combinational; no handshake.
module lowest_set_bit_encoder #(
    parameter int NUM_REGS      = 16,
    parameter int REG_IDX_WIDTH = 4
) (
    input  logic [NUM_REGS-1:0]      mask,
    output logic [REG_IDX_WIDTH-1:0] idx,
    output logic [NUM_REGS-1:0]      onehot,
    output logic                     single
);

    always_comb begin
        onehot = mask & (~mask + NUM_REGS'(1));
        idx    = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask[i]) idx = REG_IDX_WIDTH'(i);
        end
        // One bit left exactly when clearing the lowest leaves nothing.
        single = (mask != '0) && ((mask & ~onehot) == '0);
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Turns one LDM/STM request into one address beat per listed register, then a done pulse with the base write-back.
// Latency: first beat the cycle after start, done the cycle after the last handshake; beats hold while beat_ready_in=0.
module ldm_stm_sequencer
    import ldm_stm_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int NUM_REGS      = 16,
    parameter int REG_IDX_WIDTH = 4,
    parameter int TAG_WIDTH     = 4
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     start_in,
    output logic                     start_ready_out,
    input  logic [NUM_REGS-1:0]      reg_list_in,
    input  logic [ADDR_WIDTH-1:0]    base_addr_in,
    input  logic                     pre_index_in,
    input  logic                     up_in,
    input  logic                     writeback_in,
    input  logic                     load_in,
    input  logic [TAG_WIDTH-1:0]     instr_tag_in,
    output logic                     beat_valid_out,
    input  logic                     beat_ready_in,
    output logic [ADDR_WIDTH-1:0]    beat_addr_out,
    output logic [REG_IDX_WIDTH-1:0] beat_reg_idx_out,
    output logic                     beat_load_out,
    output logic                     beat_last_out,
    output logic [TAG_WIDTH-1:0]     beat_tag_out,
    input  logic                     flush_in,
    output logic                     busy_out,
    output logic                     done_out,
    output logic                     wb_en_out,
    output logic [ADDR_WIDTH-1:0]    wb_data_out
);

    localparam int CNT_W = $clog2(NUM_REGS + 1);

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    state_t state_q, state_d;
    logic   beat_valid_q, beat_valid_d;
    logic   done_q, done_d;
    logic   busy_q, busy_d;

    logic [NUM_REGS-1:0]   pending_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  load_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic                  wb_en_q;
    logic [ADDR_WIDTH-1:0] wb_data_q;

    logic [REG_IDX_WIDTH-1:0] enc_idx;
    logic [NUM_REGS-1:0]      enc_onehot;
    logic                     enc_single;

    logic                  accept;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] word;
    logic [ADDR_WIDTH-1:0] span;
    logic [ADDR_WIDTH-1:0] first_addr;
    logic [ADDR_WIDTH-1:0] wb_calc;

    lowest_set_bit_encoder #(
        .NUM_REGS      (NUM_REGS),
        .REG_IDX_WIDTH (REG_IDX_WIDTH)
    ) u_enc (
        .mask   (pending_q),
        .idx    (enc_idx),
        .onehot (enc_onehot),
        .single (enc_single)
    );

    // Flush wins over both a new start and an in-flight handshake.
    assign accept    = (state_q == ST_IDLE) && start_in && !flush_in;
    assign handshake = beat_valid_q && beat_ready_in && !flush_in;

    always_comb begin
        word = ADDR_WIDTH'(WORD_BYTES);
        span = ADDR_WIDTH'(popcount(reg_list_in)) * word;
        case (amode_t'({pre_index_in, up_in}))
            AM_IA:   first_addr = base_addr_in;
            AM_IB:   first_addr = base_addr_in + word;
            AM_DA:   first_addr = base_addr_in - span + word;
            default: first_addr = base_addr_in - span;
        endcase
        wb_calc = up_in ? (base_addr_in + span) : (base_addr_in - span);
    end

    // State register; beat_valid/done/busy are registered alongside it.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= ST_IDLE;
            beat_valid_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_valid_q <= beat_valid_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (reg_list_in == '0) ? ST_DONE : ST_BEAT;
            ST_BEAT: if (handshake && enc_single) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_in) state_d = ST_IDLE;
    end

    always_comb begin
        beat_valid_d = (state_d == ST_BEAT);
        done_d       = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            pending_q <= '0;
            addr_q    <= '0;
            load_q    <= 1'b0;
            tag_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_data_q <= '0;
        end else if (accept) begin
            pending_q <= reg_list_in;
            addr_q    <= first_addr;
            load_q    <= load_in;
            tag_q     <= instr_tag_in;
            wb_en_q   <= writeback_in;
            wb_data_q <= wb_calc;
        end else if (handshake) begin
            pending_q <= pending_q & ~enc_onehot;
            addr_q    <= addr_q + word;
        end
    end

    assign start_ready_out  = (state_q == ST_IDLE);
    assign beat_valid_out   = beat_valid_q;
    assign beat_addr_out    = addr_q;
    assign beat_reg_idx_out = beat_valid_q ? enc_idx : '0;
    assign beat_last_out    = beat_valid_q && enc_single;
    assign beat_load_out    = load_q;
    assign beat_tag_out     = tag_q;
    assign busy_out         = busy_q;
    assign done_out         = done_q;
    assign wb_en_out        = done_q && wb_en_q;
    assign wb_data_out      = done_q ? wb_data_q : '0;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: addressing modes, backpressure, empty list, busy start, flush, reset.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        start_in;
    logic        start_ready_out;
    logic [15:0] reg_list_in;
    logic [31:0] base_addr_in;
    logic        pre_index_in;
    logic        up_in;
    logic        writeback_in;
    logic        load_in;
    logic [3:0]  instr_tag_in;
    logic        beat_valid_out;
    logic        beat_ready_in;
    logic [31:0] beat_addr_out;
    logic [3:0]  beat_reg_idx_out;
    logic        beat_load_out;
    logic        beat_last_out;
    logic [3:0]  beat_tag_out;
    logic        flush_in;
    logic        busy_out;
    logic        done_out;
    logic        wb_en_out;
    logic [31:0] wb_data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ldm_stm_sequencer #(
        .ADDR_WIDTH    (32),
        .NUM_REGS      (16),
        .REG_IDX_WIDTH (4),
        .TAG_WIDTH     (4)
    ) dut (
        .clk_in           (clk),
        .reset_in         (reset_in),
        .start_in         (start_in),
        .start_ready_out  (start_ready_out),
        .reg_list_in      (reg_list_in),
        .base_addr_in     (base_addr_in),
        .pre_index_in     (pre_index_in),
        .up_in            (up_in),
        .writeback_in     (writeback_in),
        .load_in          (load_in),
        .instr_tag_in     (instr_tag_in),
        .beat_valid_out   (beat_valid_out),
        .beat_ready_in    (beat_ready_in),
        .beat_addr_out    (beat_addr_out),
        .beat_reg_idx_out (beat_reg_idx_out),
        .beat_load_out    (beat_load_out),
        .beat_last_out    (beat_last_out),
        .beat_tag_out     (beat_tag_out),
        .flush_in         (flush_in),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .wb_en_out        (wb_en_out),
        .wb_data_out      (wb_data_out)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] addr, input logic [3:0] idx,
                            input logic last);
        chk({tag, "_vld"}, 32'(beat_valid_out), 32'd1);
        chk({tag, "_addr"}, beat_addr_out, addr);
        chk({tag, "_idx"}, 32'(beat_reg_idx_out), 32'(idx));
        chk({tag, "_last"}, 32'(beat_last_out), 32'(last));
    endtask

    task automatic chk_done(input string tag, input logic wb_en, input logic [31:0] wb_data);
        chk({tag, "_done"}, 32'(done_out), 32'd1);
        chk({tag, "_vld"}, 32'(beat_valid_out), 32'd0);
        chk({tag, "_wben"}, 32'(wb_en_out), 32'(wb_en));
        chk({tag, "_wbdat"}, wb_data_out, wb_data);
    endtask

    task automatic start_req(input logic [15:0] list, input logic [31:0] base, input logic p,
                             input logic u, input logic w, input logic l, input logic [3:0] tag);
        reg_list_in  = list;
        base_addr_in = base;
        pre_index_in = p;
        up_in        = u;
        writeback_in = w;
        load_in      = l;
        instr_tag_in = tag;
        start_in     = 1'b1;
        tick();
        start_in     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_in      = 1'b1;
        start_in      = 1'b0;
        reg_list_in   = '0;
        base_addr_in  = '0;
        pre_index_in  = 1'b0;
        up_in         = 1'b0;
        writeback_in  = 1'b0;
        load_in       = 1'b0;
        instr_tag_in  = '0;
        beat_ready_in = 1'b1;
        flush_in      = 1'b0;
        tick();
        tick();
        reset_in = 1'b0;

        // Reset state
        chk("rst_start_rdy", 32'(start_ready_out), 32'd1);
        chk("rst_vld", 32'(beat_valid_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_addr", beat_addr_out, 32'h0);
        chk("rst_wbdat", wb_data_out, 32'h0);

        // LDMIA 0x1000 {r1,r3,r7} W=1
        start_req(16'h008A, 32'h1000, 1'b0, 1'b1, 1'b1, 1'b1, 4'h5);
        chk_beat("ia_b0", 32'h1000, 4'd1, 1'b0);
        chk("ia_load", 32'(beat_load_out), 32'd1);
        chk("ia_tag", 32'(beat_tag_out), 32'h5);
        chk("ia_busy", 32'(busy_out), 32'd1);
        chk("ia_start_rdy", 32'(start_ready_out), 32'd0);
        tick();
        chk_beat("ia_b1", 32'h1004, 4'd3, 1'b0);
        tick();
        chk_beat("ia_b2", 32'h1008, 4'd7, 1'b1);
        tick();
        chk_done("ia", 1'b1, 32'h100C);
        tick();
        chk("ia_idle_done", 32'(done_out), 32'd0);
        chk("ia_idle_rdy", 32'(start_ready_out), 32'd1);

        // STMDB 0x2000 {r2,r4} W=1
        start_req(16'h0014, 32'h2000, 1'b1, 1'b0, 1'b1, 1'b0, 4'hA);
        chk_beat("db_b0", 32'h1FF8, 4'd2, 1'b0);
        chk("db_load", 32'(beat_load_out), 32'd0);
        tick();
        chk_beat("db_b1", 32'h1FFC, 4'd4, 1'b1);
        tick();
        chk_done("db", 1'b1, 32'h1FF8);
        tick();

        // LDMIB 0x3000 {r15} W=0
        start_req(16'h8000, 32'h3000, 1'b1, 1'b1, 1'b0, 1'b1, 4'h3);
        chk_beat("ib_b0", 32'h3004, 4'd15, 1'b1);
        tick();
        chk_done("ib", 1'b0, 32'h3004);
        tick();

        // LDMDA 0x100 {r0,r1} with backpressure on the first beat
        beat_ready_in = 1'b0;
        start_req(16'h0003, 32'h0100, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1);
        chk_beat("da_b0", 32'h00FC, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_beat("da_hold", 32'h00FC, 4'd0, 1'b0);
        end
        beat_ready_in = 1'b1;
        tick();
        chk_beat("da_b1", 32'h0100, 4'd1, 1'b1);
        tick();
        chk_done("da", 1'b1, 32'h00F8);
        tick();

        // Empty list: straight to done
        start_req(16'h0000, 32'h0040, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2);
        chk_done("empty", 1'b1, 32'h0040);
        chk("empty_busy", 32'(busy_out), 32'd1);
        tick();
        chk("empty_idle", 32'(start_ready_out), 32'd1);

        // Start while busy is dropped
        beat_ready_in = 1'b0;
        start_req(16'h0001, 32'h0500, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6);
        chk_beat("busy_b0", 32'h0500, 4'd0, 1'b1);
        start_req(16'hFFFF, 32'h9000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h9);
        chk_beat("busy_hold", 32'h0500, 4'd0, 1'b1);
        chk("busy_tag", 32'(beat_tag_out), 32'h6);
        beat_ready_in = 1'b1;
        tick();
        chk_done("busy", 1'b0, 32'h0504);
        tick();
        chk("busy_nq_vld", 32'(beat_valid_out), 32'd0);
        chk("busy_nq_rdy", 32'(start_ready_out), 32'd1);
        tick();
        chk("busy_nq_vld2", 32'(beat_valid_out), 32'd0);
        chk("busy_nq_done", 32'(done_out), 32'd0);

        // Flush on the second beat of a 4-register sequence
        start_req(16'h000F, 32'h0800, 1'b0, 1'b1, 1'b1, 1'b1, 4'h7);
        chk_beat("fl_b0", 32'h0800, 4'd0, 1'b0);
        tick();
        chk_beat("fl_b1", 32'h0804, 4'd1, 1'b0);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("fl_vld", 32'(beat_valid_out), 32'd0);
        chk("fl_done", 32'(done_out), 32'd0);
        chk("fl_busy", 32'(busy_out), 32'd0);
        chk("fl_rdy", 32'(start_ready_out), 32'd1);
        tick();
        chk("fl_done2", 32'(done_out), 32'd0);

        // Flush and start together in IDLE: start dropped
        flush_in = 1'b1;
        start_req(16'h0003, 32'h0C00, 1'b0, 1'b1, 1'b1, 1'b1, 4'h8);
        flush_in = 1'b0;
        chk("flst_vld", 32'(beat_valid_out), 32'd0);
        chk("flst_busy", 32'(busy_out), 32'd0);
        chk("flst_rdy", 32'(start_ready_out), 32'd1);

        // Reset mid-sequence
        start_req(16'h000F, 32'h0A00, 1'b0, 1'b1, 1'b1, 1'b1, 4'hC);
        tick();
        chk_beat("rs_b1", 32'h0A04, 4'd1, 1'b0);
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        chk("rs_vld", 32'(beat_valid_out), 32'd0);
        chk("rs_addr", beat_addr_out, 32'h0);
        chk("rs_idx", 32'(beat_reg_idx_out), 32'd0);
        chk("rs_last", 32'(beat_last_out), 32'd0);
        chk("rs_load", 32'(beat_load_out), 32'd0);
        chk("rs_tag", 32'(beat_tag_out), 32'd0);
        chk("rs_busy", 32'(busy_out), 32'd0);
        chk("rs_rdy", 32'(start_ready_out), 32'd1);
        tick();
        chk("rs_done", 32'(done_out), 32'd0);
        chk("rs_wben", 32'(wb_en_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
